// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit that sits at the ID stage of the
// pipelined RISC-V core. A shift-register scoreboard records the destination
// register of each of the last DEPTH in-flight instructions (entry 0 = EX,
// entry 1 = MEM, entry 2 = WB, ...). For each source operand the youngest
// matching producer is chosen as the forwarding source. A load whose result is
// not yet available in its current stage causes a stall.
//
// Parameters:
//   DEPTH       number of tracked producer stages (>= 1)
//   LOAD_READY  lowest entry index from which a load result can be forwarded
//   SEL_W       width of the forward-select outputs
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   id_valid         ID holds a real instruction
//   id_instr         instruction word in ID (rs1 [19:15], rs2 [24:20], rd [11:7])
//   id_reads_rs1/2   operand is actually used by the instruction
//   id_writes_rd     instruction writes rd
//   id_is_load       instruction is a load
//   flush            squash the ID instruction and the EX entry
//   stall            hold PC and IF/ID, insert a bubble into EX
//   issue            ID instruction moves into EX this cycle
//   fwd_sel_rs1/2    0 = register file, k+1 = forward from entry k
//   stall_count      saturating count of stall cycles
//
// Handshake: the ID instruction is offered whenever id_valid = 1. It is taken
// (issue = 1) in exactly the cycle where there is no stall and no flush; while
// stall = 1 the upstream must keep the same instruction and qualifiers stable.
// flush drops the offer without taking it.

module fwd_hazard_unit #(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             id_reads_rs1,
    input  logic             id_reads_rs2,
    input  logic             id_writes_rd,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [SEL_W-1:0] fwd_sel_rs1,
    output logic [SEL_W-1:0] fwd_sel_rs2,
    output logic [31:0]      stall_count
);

    // Scoreboard: one {valid, rd, is_load} record per tracked stage.
    logic [DEPTH-1:0] sb_valid;
    logic [4:0]       sb_rd [DEPTH];
    logic [DEPTH-1:0] sb_load;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;

    logic [SEL_W-1:0] sel_rs1;
    logic [SEL_W-1:0] sel_rs2;
    logic             haz_rs1;
    logic             haz_rs2;

    // Opcode/funct/immediate bits are not needed here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12], id_instr[6:0]};

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign rd  = id_instr[11:7];

    // x0 is hard-wired zero and is never forwarded.
    assign use_rs1 = id_reads_rs1 && (rs1 != 5'd0);
    assign use_rs2 = id_reads_rs2 && (rs2 != 5'd0);

    // Walk from oldest to youngest so the lowest-index match is the last
    // assignment and therefore wins.
    always_comb begin
        sel_rs1 = '0;
        haz_rs1 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_rs1 && sb_valid[k] && (sb_rd[k] == rs1)) begin
                sel_rs1 = SEL_W'(k + 1);
                haz_rs1 = sb_load[k] && (k < LOAD_READY);
            end
        end
    end

    always_comb begin
        sel_rs2 = '0;
        haz_rs2 = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_rs2 && sb_valid[k] && (sb_rd[k] == rs2)) begin
                sel_rs2 = SEL_W'(k + 1);
                haz_rs2 = sb_load[k] && (k < LOAD_READY);
            end
        end
    end

    // Flush outranks a hazard: the consumer is being squashed anyway.
    assign stall       = id_valid && (haz_rs1 || haz_rs2) && !flush;
    assign issue       = id_valid && !stall && !flush;
    assign fwd_sel_rs1 = id_valid ? sel_rs1 : '0;
    assign fwd_sel_rs2 = id_valid ? sel_rs2 : '0;

    // The scoreboard shifts every cycle; a stall or flush simply inserts a
    // bubble at entry 0. A flush also kills the instruction leaving EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_valid    <= '0;
            sb_load     <= '0;
            stall_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_rd[k] <= 5'd0;
            end
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb_valid[k] <= sb_valid[k-1] && !(flush && (k == 1));
                sb_rd[k]    <= sb_rd[k-1];
                sb_load[k]  <= sb_load[k-1];
            end
            sb_valid[0] <= issue && id_writes_rd && (rd != 5'd0);
            sb_rd[0]    <= rd;
            sb_load[0]  <= id_is_load;
            if (stall && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a default instance (DEPTH 3, LOAD_READY 1) and a
// deeper instance (DEPTH 4, LOAD_READY 2) share one stimulus stream. Each is
// checked every cycle against a list-of-in-flight-instructions model, plus
// directed sequences with hand-computed expectations.

module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        id_reads_rs1;
    logic        id_reads_rs2;
    logic        id_writes_rd;
    logic        id_is_load;
    logic        flush;

    logic        stall_a, issue_a;
    logic [1:0]  s1_a, s2_a;
    logic [31:0] cnt_a;
    logic        stall_b, issue_b;
    logic [2:0]  s1_b, s2_b;
    logic [31:0] cnt_b;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fwd_hazard_unit dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_reads_rs1(id_reads_rs1), .id_reads_rs2(id_reads_rs2),
        .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_a), .issue(issue_a), .fwd_sel_rs1(s1_a), .fwd_sel_rs2(s2_a),
        .stall_count(cnt_a)
    );

    fwd_hazard_unit #(.DEPTH(4), .LOAD_READY(2)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_reads_rs1(id_reads_rs1), .id_reads_rs2(id_reads_rs2),
        .id_writes_rd(id_writes_rd), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_b), .issue(issue_b), .fwd_sel_rs1(s1_b), .fwd_sel_rs2(s2_b),
        .stall_count(cnt_b)
    );

    // ---------------- reference model ----------------
    // In-flight instructions by age (index 0 = most recently entered EX).
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } rec_t;

    rec_t        hist_a[$];
    rec_t        hist_b[$];
    logic [31:0] ecnt_a = 32'd0;
    logic [31:0] ecnt_b = 32'd0;

    function automatic int find_src(input rec_t h[$], input int depth,
                                    input logic en, input logic [4:0] rs);
        if (!en || rs == 5'd0) return 0;
        for (int k = 0; k < depth && k < h.size(); k++) begin
            if (h[k].v && h[k].rd == rs) return k + 1;
        end
        return 0;
    endfunction

    function automatic void model_eval(input rec_t h[$], input int depth, input int lr,
                                       output int s1, output int s2,
                                       output logic st, output logic is);
        logic haz;
        s1 = find_src(h, depth, id_reads_rs1, id_instr[19:15]);
        s2 = find_src(h, depth, id_reads_rs2, id_instr[24:20]);
        haz = 1'b0;
        if (s1 != 0 && h[s1-1].ld && (s1 - 1) < lr) haz = 1'b1;
        if (s2 != 0 && h[s2-1].ld && (s2 - 1) < lr) haz = 1'b1;
        st = id_valid && haz && !flush;
        is = id_valid && !st && !flush;
        if (!id_valid) begin
            s1 = 0;
            s2 = 0;
        end
    endfunction

    function automatic rec_t new_rec(input logic is);
        rec_t r;
        r.v  = is && id_writes_rd && (id_instr[11:7] != 5'd0);
        r.rd = id_instr[11:7];
        r.ld = id_is_load;
        return r;
    endfunction

    always @(posedge clk) begin
        int   s1, s2;
        logic st, is;
        if (reset) begin
            hist_a.delete();
            hist_b.delete();
            ecnt_a = 32'd0;
            ecnt_b = 32'd0;
        end else begin
            model_eval(hist_a, 3, 1, s1, s2, st, is);
            if (flush && hist_a.size() > 0) hist_a[0].v = 1'b0;
            hist_a.push_front(new_rec(is));
            while (hist_a.size() > 3) void'(hist_a.pop_back());
            if (st && ecnt_a != 32'hFFFF_FFFF) ecnt_a = ecnt_a + 32'd1;

            model_eval(hist_b, 4, 2, s1, s2, st, is);
            if (flush && hist_b.size() > 0) hist_b[0].v = 1'b0;
            hist_b.push_front(new_rec(is));
            while (hist_b.size() > 4) void'(hist_b.pop_back());
            if (st && ecnt_b != 32'hFFFF_FFFF) ecnt_b = ecnt_b + 32'd1;
        end
    end

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int   s1, s2;
        logic st, is;
        if (run_cmp) begin
            model_eval(hist_a, 3, 1, s1, s2, st, is);
            chk("a_stall", {31'd0, stall_a}, {31'd0, st});
            chk("a_issue", {31'd0, issue_a}, {31'd0, is});
            if (!st) begin
                chk("a_sel1", {30'd0, s1_a}, s1);
                chk("a_sel2", {30'd0, s2_a}, s2);
            end
            chk("a_count", cnt_a, ecnt_a);

            model_eval(hist_b, 4, 2, s1, s2, st, is);
            chk("b_stall", {31'd0, stall_b}, {31'd0, st});
            chk("b_issue", {31'd0, issue_b}, {31'd0, is});
            if (!st) begin
                chk("b_sel1", {29'd0, s1_b}, s1);
                chk("b_sel2", {29'd0, s2_b}, s2);
            end
            chk("b_count", cnt_b, ecnt_b);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    task automatic set_in(input logic v, input logic [31:0] ins, input logic r1,
                          input logic r2, input logic w, input logic ld, input logic fl);
        id_valid     = v;
        id_instr     = ins;
        id_reads_rs1 = r1;
        id_reads_rs2 = r2;
        id_writes_rd = w;
        id_is_load   = ld;
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Producer x8 <- load, consumer reads x8 on rs1.
    task automatic load_then_use(input logic fl);
        tick();
        set_in(1'b1, mk(5'd8, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        set_in(1'b1, mk(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0, fl);
        #2;
    endtask

    int exp_gap_a[5] = '{1, 2, 3, 0, 0};
    int exp_gap_b[5] = '{1, 2, 3, 4, 0};

    initial begin
        reset = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset   = 1'b0;
        run_cmp = 1'b1;
        #2;
        chk("rst_stall", {31'd0, stall_a}, 32'd0);
        chk("rst_issue", {31'd0, issue_a}, 32'd0);
        chk("rst_sel1", {30'd0, s1_a}, 32'd0);
        chk("rst_sel2", {30'd0, s2_a}, 32'd0);
        chk("rst_count_a", cnt_a, 32'd0);
        chk("rst_count_b", cnt_b, 32'd0);

        // Back-to-back ALU dependency: add x5,x1,x2 ; sub x6,x5,x5
        tick();
        set_in(1'b1, mk(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 chk("b2b_issue", {31'd0, issue_a}, 32'd1);
        tick();
        set_in(1'b1, mk(5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("b2b_sel1", {30'd0, s1_a}, 32'd1);
        chk("b2b_sel2", {30'd0, s2_a}, 32'd1);
        chk("b2b_stall", {31'd0, stall_a}, 32'd0);
        chk("b2b_sel1_b", {29'd0, s1_b}, 32'd1);
        idle(5);

        // Producer x7, gap independent instructions, consumer of x7.
        for (int gap = 0; gap < 5; gap++) begin
            tick();
            set_in(1'b1, mk(5'd7, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            repeat (gap) begin
                tick();
                set_in(1'b1, mk(5'd10, 5'd11, 5'd12), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            end
            tick();
            set_in(1'b1, mk(5'd20, 5'd7, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            #2;
            chk("dist_sel_a", {30'd0, s1_a}, exp_gap_a[gap]);
            chk("dist_sel_b", {29'd0, s1_b}, exp_gap_b[gap]);
            chk("dist_x0_a", {30'd0, s2_a}, 32'd0);
            idle(5);
        end

        // Load-use
        load_then_use(1'b0);
        chk("lu_stall_a", {31'd0, stall_a}, 32'd1);
        chk("lu_issue_a", {31'd0, issue_a}, 32'd0);
        chk("lu_stall_b", {31'd0, stall_b}, 32'd1);
        tick();
        #2;
        chk("lu2_stall_a", {31'd0, stall_a}, 32'd0);
        chk("lu2_issue_a", {31'd0, issue_a}, 32'd1);
        chk("lu2_sel_a", {30'd0, s1_a}, 32'd2);
        chk("lu2_count_a", cnt_a, 32'd1);
        chk("lu2_stall_b", {31'd0, stall_b}, 32'd1);
        tick();
        #2;
        chk("lu3_stall_b", {31'd0, stall_b}, 32'd0);
        chk("lu3_issue_b", {31'd0, issue_b}, 32'd1);
        chk("lu3_sel_b", {29'd0, s1_b}, 32'd3);
        chk("lu3_count_b", cnt_b, 32'd2);
        idle(5);

        // x0 never forwarded; unused operand not forwarded
        tick();
        set_in(1'b1, mk(5'd0, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, mk(5'd9, 5'd0, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("x0_sel1", {30'd0, s1_a}, 32'd0);
        chk("x0_sel2", {30'd0, s2_a}, 32'd0);
        tick();
        set_in(1'b1, mk(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, mk(5'd9, 5'd5, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("gate_sel1", {30'd0, s1_a}, 32'd1);
        chk("gate_sel2", {30'd0, s2_a}, 32'd0);
        idle(5);

        // Flush during hazard
        load_then_use(1'b1);
        chk("fl_stall_a", {31'd0, stall_a}, 32'd0);
        chk("fl_issue_a", {31'd0, issue_a}, 32'd0);
        chk("fl_stall_b", {31'd0, stall_b}, 32'd0);
        tick();
        set_in(1'b1, mk(5'd9, 5'd8, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("fl2_count_a", cnt_a, 32'd1);
        chk("fl2_count_b", cnt_b, 32'd2);
        chk("fl2_stall_a", {31'd0, stall_a}, 32'd0);
        chk("fl2_sel_a", {30'd0, s1_a}, 32'd0);
        chk("fl2_stall_b", {31'd0, stall_b}, 32'd0);
        chk("fl2_sel_b", {29'd0, s1_b}, 32'd0);
        idle(5);

        // Reset in the middle of a stall
        load_then_use(1'b0);
        chk("rs_stall_a", {31'd0, stall_a}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("rs2_stall_a", {31'd0, stall_a}, 32'd0);
        chk("rs2_sel1_a", {30'd0, s1_a}, 32'd0);
        chk("rs2_sel2_a", {30'd0, s2_a}, 32'd0);
        chk("rs2_count_a", cnt_a, 32'd0);
        chk("rs2_stall_b", {31'd0, stall_b}, 32'd0);
        chk("rs2_count_b", cnt_b, 32'd0);
        idle(5);

        // Randomized traffic on a small register set to provoke matches
        repeat (3000) begin
            tick();
            reset = ($urandom_range(0, 63) == 0);
            set_in(($urandom_range(0, 4) != 0),
                   mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3))),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 7) == 0));
        end
        tick();
        run_cmp = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
